// File: rtl/wbuf_pkg.sv
// Shared constants and helpers for the ping-pong weight buffer.
// Half occupancy encoding, row-width derivation and read-latency legality.
package wbuf_pkg;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    function automatic int unsigned row_width(input int unsigned num_banks,
                                              input int unsigned data_width);
        return num_banks * data_width;
    endfunction

    function automatic bit read_latency_ok(input int unsigned read_latency);
        return (read_latency == 32'd1) || (read_latency == 32'd2);
    endfunction

endpackage

// File: rtl/weight_buffer_pingpong_if.sv
// Loader/array-facing bus of the ping-pong weight buffer.
// WBUF_PARITY_EN adds inj_parity_err and rd_parity_err.
interface weight_buffer_pingpong_if
    import wbuf_pkg::*;
#(
    parameter int unsigned NUM_BANKS  = 64,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 6
);
    localparam int unsigned ROW_WIDTH = row_width(NUM_BANKS, DATA_WIDTH);

    logic                  wr_req;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ROW_WIDTH-1:0]  wr_data;
    logic                  wr_done;
    logic                  wr_ready;
    logic                  rd_req;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  rd_done;
    logic                  rd_ready;
    logic [ROW_WIDTH-1:0]  rd_data;
    logic                  rd_valid;
    logic                  wr_err;
    logic                  rd_err;
`ifdef WBUF_PARITY_EN
    logic [NUM_BANKS-1:0]  inj_parity_err;
    logic [NUM_BANKS-1:0]  rd_parity_err;

    modport master (
        output wr_req, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_done, inj_parity_err,
        input  wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err, rd_parity_err
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_done, inj_parity_err,
        output wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err, rd_parity_err
    );
`else
    modport master (
        output wr_req, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_done,
        input  wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err
    );
    modport slave (
        input  wr_req, wr_addr, wr_data, wr_done, rd_req, rd_addr, rd_done,
        output wr_ready, rd_ready, rd_data, rd_valid, wr_err, rd_err
    );
`endif

endinterface

// File: rtl/weight_bank_ram.sv
// One bank of the weight buffer: simple dual-port RAM, 1-cycle registered read.
// WBUF_FPGA_XPM maps the array onto xpm_memory_sdpram; otherwise behavioural.
module weight_bank_ram #(
    parameter int unsigned ADDR_WIDTH = 7,
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);
    localparam int unsigned WORDS = 32'd1 << ADDR_WIDTH;

`ifdef WBUF_FPGA_XPM
    xpm_memory_sdpram #(
        .ADDR_WIDTH_A       (ADDR_WIDTH),
        .ADDR_WIDTH_B       (ADDR_WIDTH),
        .BYTE_WRITE_WIDTH_A (DATA_WIDTH),
        .CLOCKING_MODE      ("common_clock"),
        .MEMORY_PRIMITIVE   ("auto"),
        .MEMORY_SIZE        (WORDS * DATA_WIDTH),
        .READ_DATA_WIDTH_B  (DATA_WIDTH),
        .READ_LATENCY_B     (1),
        .WRITE_DATA_WIDTH_A (DATA_WIDTH),
        .WRITE_MODE_B       ("read_first")
    ) u_xpm (
        .clka           (clk),
        .ena            (we),
        .wea            (we),
        .addra          (waddr),
        .dina           (wdata),
        .injectsbiterra (1'b0),
        .injectdbiterra (1'b0),
        .clkb           (clk),
        .enb            (re),
        .regceb         (1'b1),
        .rstb           (reset),
        .addrb          (raddr),
        .doutb          (rdata),
        .sbiterrb       (),
        .dbiterrb       (),
        .sleep          (1'b0)
    );
`else
    logic [DATA_WIDTH-1:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Output register only moves on a read, so it holds between reads.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end
`endif

endmodule

// File: rtl/weight_buffer_pingpong.sv
// Double-buffered multi-bank weight buffer: loader fills one half while the array reads the other.
// WBUF_PARITY_EN adds per-bank even parity (inj_parity_err / rd_parity_err on the bus).
module weight_buffer_pingpong
    import wbuf_pkg::*;
#(
    parameter int unsigned NUM_BANKS    = 64,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned DEPTH        = 64,
    parameter int unsigned ADDR_WIDTH   = 6,
    parameter int unsigned READ_LATENCY = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    weight_buffer_pingpong_if.slave  bus
);
    localparam int unsigned ROW_WIDTH = row_width(NUM_BANKS, DATA_WIDTH);
    localparam int unsigned RAM_AW    = ADDR_WIDTH + 1;
`ifdef WBUF_PARITY_EN
    localparam int unsigned RAM_WIDTH = DATA_WIDTH + 1;
`else
    localparam int unsigned RAM_WIDTH = DATA_WIDTH;
`endif

    if (!read_latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("weight_buffer_pingpong: READ_LATENCY must be 1 or 2");
    end
    if (DEPTH != (32'd1 << ADDR_WIDTH)) begin : g_bad_depth
        $error("weight_buffer_pingpong: DEPTH must equal 2**ADDR_WIDTH");
    end

    logic [1:0] state, state_nxt;
    logic       wr_sel, wr_sel_nxt;
    logic       rd_sel, rd_sel_nxt;
    logic       wr_err_q, rd_err_q;
    logic       wr_ready_c, rd_ready_c;
    logic       wr_acc_c, rd_acc_c;
    logic       rd_v1;
    logic [ROW_WIDTH-1:0] ram_row;

    assign wr_ready_c = (state[wr_sel] == ST_EMPTY);
    assign rd_ready_c = (state[rd_sel] == ST_FULL);
    assign wr_acc_c   = bus.wr_req & wr_ready_c;
    assign rd_acc_c   = bus.rd_req & rd_ready_c;

    // Handoff: done pulses flip the targeted half and advance that side's pointer.
    always_comb begin
        state_nxt  = state;
        wr_sel_nxt = wr_sel;
        rd_sel_nxt = rd_sel;
        if (bus.wr_done && wr_ready_c) begin
            state_nxt[wr_sel] = ST_FULL;
            wr_sel_nxt        = ~wr_sel;
        end
        if (bus.rd_done && rd_ready_c) begin
            state_nxt[rd_sel] = ST_EMPTY;
            rd_sel_nxt        = ~rd_sel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= {ST_EMPTY, ST_EMPTY};
            wr_sel   <= 1'b0;
            rd_sel   <= 1'b0;
            wr_err_q <= 1'b0;
            rd_err_q <= 1'b0;
            rd_v1    <= 1'b0;
        end else begin
            state  <= state_nxt;
            wr_sel <= wr_sel_nxt;
            rd_sel <= rd_sel_nxt;
            rd_v1  <= rd_acc_c;
            if ((bus.wr_req || bus.wr_done) && !wr_ready_c) begin
                wr_err_q <= 1'b1;
            end
            if ((bus.rd_req || bus.rd_done) && !rd_ready_c) begin
                rd_err_q <= 1'b1;
            end
        end
    end

    assign bus.wr_ready = wr_ready_c;
    assign bus.rd_ready = rd_ready_c;
    assign bus.wr_err   = wr_err_q;
    assign bus.rd_err   = rd_err_q;

`ifdef WBUF_PARITY_EN
    logic [NUM_BANKS-1:0] perr_c;
`endif

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [RAM_WIDTH-1:0] wdata;
        logic [RAM_WIDTH-1:0] rdata;
`ifdef WBUF_PARITY_EN
        // Stored bit makes the word even; a flipped bit shows up as odd on readback.
        assign wdata     = {(^bus.wr_data[b*DATA_WIDTH +: DATA_WIDTH]) ^ bus.inj_parity_err[b],
                            bus.wr_data[b*DATA_WIDTH +: DATA_WIDTH]};
        assign perr_c[b] = ^rdata;
`else
        assign wdata = bus.wr_data[b*DATA_WIDTH +: DATA_WIDTH];
`endif
        assign ram_row[b*DATA_WIDTH +: DATA_WIDTH] = rdata[DATA_WIDTH-1:0];

        weight_bank_ram #(
            .ADDR_WIDTH (RAM_AW),
            .DATA_WIDTH (RAM_WIDTH)
        ) u_ram (
            .clk   (clk),
            .reset (reset),
            .we    (wr_acc_c),
            .waddr ({wr_sel, bus.wr_addr}),
            .wdata (wdata),
            .re    (rd_acc_c),
            .raddr ({rd_sel, bus.rd_addr}),
            .rdata (rdata)
        );
    end

    if (READ_LATENCY == 32'd2) begin : g_lat2
        logic [ROW_WIDTH-1:0] data_q;
        logic                 valid_q;
`ifdef WBUF_PARITY_EN
        logic [NUM_BANKS-1:0] perr_q;
`endif
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                data_q  <= '0;
                valid_q <= 1'b0;
`ifdef WBUF_PARITY_EN
                perr_q  <= '0;
`endif
            end else begin
                valid_q <= rd_v1;
                if (rd_v1) begin
                    data_q <= ram_row;
                end
`ifdef WBUF_PARITY_EN
                perr_q  <= rd_v1 ? perr_c : '0;
`endif
            end
        end
        assign bus.rd_data  = data_q;
        assign bus.rd_valid = valid_q;
`ifdef WBUF_PARITY_EN
        assign bus.rd_parity_err = perr_q;
`endif
    end else begin : g_lat1
        assign bus.rd_data  = ram_row;
        assign bus.rd_valid = rd_v1;
`ifdef WBUF_PARITY_EN
        assign bus.rd_parity_err = rd_v1 ? perr_c : '0;
`endif
    end

endmodule
